alu_pipe: RTL and testbench



---
 rtl/alu_pipe.sv | 185 ++++++++++++++++++
 tb/tb_alu_pipe.sv | 312 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// alu_pipe: two-stage pipelined ALU with valid/ready handshake on both sides
// and the architectural {Z, V, N} flag register.
module alu_pipe #(
  parameter int WIDTH = 16,
  parameter bit SAT   = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [2:0]       opcode,
  input  logic [WIDTH-1:0] alu_in1,
  input  logic [WIDTH-1:0] alu_in2,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] alu_out,
  output logic [2:0]       flags
);

  localparam int SHW = $clog2(WIDTH);

  localparam logic [2:0] OP_ADD    = 3'd0;
  localparam logic [2:0] OP_SUB    = 3'd1;
  localparam logic [2:0] OP_XOR    = 3'd2;
  localparam logic [2:0] OP_RED    = 3'd3;
  localparam logic [2:0] OP_SLL    = 3'd4;
  localparam logic [2:0] OP_SRA    = 3'd5;
  localparam logic [2:0] OP_ROR    = 3'd6;
  localparam logic [2:0] OP_PADDSB = 3'd7;

  // Stage A: captured operation
  logic             a_valid;
  logic [2:0]       a_op;
  logic [WIDTH-1:0] a_in1;
  logic [WIDTH-1:0] a_in2;

  // Stage B: computed result plus per-op flag values and update mask
  logic             b_valid;
  logic [WIDTH-1:0] b_out;
  logic             b_z;
  logic             b_v;
  logic             b_n;
  logic             b_upd_all;
  logic             b_upd_z;

  logic b_fire;
  logic a_adv;
  logic accept;

  assign b_fire   = b_valid & out_ready;
  assign a_adv    = a_valid & (~b_valid | out_ready);
  assign in_ready = ~a_valid | a_adv;
  assign accept   = in_valid & in_ready;

  assign out_valid = b_valid;
  assign alu_out   = b_out;

  // Execute-stage datapath
  logic [WIDTH-1:0]   sum;
  logic [WIDTH-1:0]   diff;
  logic               add_ovf;
  logic               sub_ovf;
  logic [WIDTH-1:0]   sat_val;
  logic [SHW-1:0]     sh;
  logic [2*WIDTH-1:0] rot;
  logic [WIDTH-1:0]   res;
  logic               ovf;
  logic               upd_all;
  logic               upd_z;
  logic [7:0]         red;
  logic [4:0]         lane;

  assign sum     = a_in1 + a_in2;
  assign diff    = a_in1 - a_in2;
  assign add_ovf = (a_in1[WIDTH-1] == a_in2[WIDTH-1]) & (sum[WIDTH-1]  != a_in1[WIDTH-1]);
  assign sub_ovf = (a_in1[WIDTH-1] != a_in2[WIDTH-1]) & (diff[WIDTH-1] != a_in1[WIDTH-1]);
  // Overflow direction follows the sign of alu_in1: negative in1 can only underflow.
  assign sat_val = a_in1[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
  assign sh      = a_in2[SHW-1:0];
  assign rot     = {a_in1, a_in1} >> sh;

  // Result selection and which flags this op is allowed to update
  always_comb begin
    res     = '0;
    ovf     = 1'b0;
    upd_all = 1'b0;
    upd_z   = 1'b0;
    red     = '0;
    lane    = '0;
    case (a_op)
      OP_ADD: begin
        ovf     = add_ovf;
        res     = (add_ovf && SAT) ? sat_val : sum;
        upd_all = 1'b1;
      end
      OP_SUB: begin
        ovf     = sub_ovf;
        res     = (sub_ovf && SAT) ? sat_val : diff;
        upd_all = 1'b1;
      end
      OP_XOR: begin
        res   = a_in1 ^ a_in2;
        upd_z = 1'b1;
      end
      OP_RED: begin
        for (int unsigned i = 0; i < WIDTH/8; i++) begin
          red = red + a_in1[8*i +: 8] + a_in2[8*i +: 8];
        end
        res = {{(WIDTH-8){red[7]}}, red};
      end
      OP_SLL: begin
        res   = a_in1 << sh;
        upd_z = 1'b1;
      end
      OP_SRA: begin
        res   = $signed(a_in1) >>> sh;
        upd_z = 1'b1;
      end
      OP_ROR: begin
        res   = rot[WIDTH-1:0];
        upd_z = 1'b1;
      end
      default: begin
        for (int unsigned i = 0; i < WIDTH/4; i++) begin
          lane = {a_in1[4*i+3], a_in1[4*i +: 4]} + {a_in2[4*i+3], a_in2[4*i +: 4]};
          res[4*i +: 4] = (lane[4] != lane[3]) ? (lane[4] ? 4'h8 : 4'h7) : lane[3:0];
        end
      end
    endcase
  end

  // Stage A: load on accept, empty when it moves into B without a replacement
  always_ff @(posedge clk) begin
    if (rst) begin
      a_valid <= 1'b0;
      a_op    <= '0;
      a_in1   <= '0;
      a_in2   <= '0;
    end else if (accept) begin
      a_valid <= 1'b1;
      a_op    <= opcode;
      a_in1   <= alu_in1;
      a_in2   <= alu_in2;
    end else if (a_adv) begin
      a_valid <= 1'b0;
    end
  end

  // Stage B: load from A when it advances, otherwise hold until drained
  always_ff @(posedge clk) begin
    if (rst) begin
      b_valid   <= 1'b0;
      b_out     <= '0;
      b_z       <= 1'b0;
      b_v       <= 1'b0;
      b_n       <= 1'b0;
      b_upd_all <= 1'b0;
      b_upd_z   <= 1'b0;
    end else if (a_adv) begin
      b_valid   <= 1'b1;
      b_out     <= res;
      b_z       <= (res == '0);
      b_v       <= ovf;
      b_n       <= res[WIDTH-1];
      b_upd_all <= upd_all;
      b_upd_z   <= upd_z;
    end else if (b_fire) begin
      b_valid <= 1'b0;
    end
  end

  // Flag register: committed only when the consumer takes the result
  always_ff @(posedge clk) begin
    if (rst) begin
      flags <= '0;
    end else if (b_fire) begin
      if (b_upd_all) begin
        flags <= {b_z, b_v, b_n};
      end else if (b_upd_z) begin
        flags[2] <= b_z;
      end
    end
  end

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe: table vectors, backpressure / reset sequences and random ops
// checked through an in-order scoreboard against a behavioural model.
module tb_alu_pipe;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [2:0]   opcode;
  logic [W-1:0] alu_in1;
  logic [W-1:0] alu_in2;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] alu_out;
  logic [2:0]   flags;

  alu_pipe #(.WIDTH(W), .SAT(1'b1)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .opcode(opcode), .alu_in1(alu_in1), .alu_in2(alu_in2),
    .out_valid(out_valid), .out_ready(out_ready),
    .alu_out(alu_out), .flags(flags)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] r;
    logic [2:0]   f;
  } vec_t;

  typedef struct {
    logic [W-1:0] r;
    logic [2:0]   f;
  } exp_t;

  exp_t       sbq[$];
  int         nvec = 0;
  int         nerr = 0;
  logic [2:0] model_flags = 3'b000;
  bit         pending = 0;
  logic [2:0] pend_flags;
  bit         rand_bp = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    nvec++;
    if (act !== expv) begin
      nerr++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, expv, $time);
    end
  endtask

  // Behavioural model of one operation, written with integer arithmetic
  task automatic model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                       input logic [2:0] fin, output logic [W-1:0] r, output logic [2:0] fout);
    int s;
    int x;
    int y;
    logic [3:0] na;
    logic [3:0] nb;
    logic [7:0] r8;
    logic [W-1:0] v;
    int unsigned amt;
    bit ov;
    amt = int'(b[3:0]);
    fout = fin;
    ov = 0;
    r = '0;
    case (op)
      3'd0, 3'd1: begin
        s = (op == 3'd0) ? int'($signed(a)) + int'($signed(b)) : int'($signed(a)) - int'($signed(b));
        if (s > 32767) begin ov = 1; r = 16'h7FFF; end
        else if (s < -32768) begin ov = 1; r = 16'h8000; end
        else r = s[W-1:0];
        fout = {r == 0, ov, r[W-1]};
      end
      3'd2: begin r = a ^ b; fout[2] = (r == 0); end
      3'd3: begin
        s = 0;
        for (int i = 0; i < W/8; i++) s = s + int'(a[8*i +: 8]) + int'(b[8*i +: 8]);
        s = s % 256;
        r8 = s[7:0];
        r = {{(W-8){r8[7]}}, r8};
      end
      3'd4: begin v = a; for (int unsigned k = 0; k < amt; k++) v = {v[W-2:0], 1'b0}; r = v; fout[2] = (r == 0); end
      3'd5: begin v = a; for (int unsigned k = 0; k < amt; k++) v = {v[W-1], v[W-1:1]}; r = v; fout[2] = (r == 0); end
      3'd6: begin v = a; for (int unsigned k = 0; k < amt; k++) v = {v[0], v[W-1:1]}; r = v; fout[2] = (r == 0); end
      default: begin
        for (int i = 0; i < W/4; i++) begin
          na = a[4*i +: 4];
          nb = b[4*i +: 4];
          x = int'($signed(na));
          y = int'($signed(nb));
          s = x + y;
          if (s > 7) s = 7;
          if (s < -8) s = -8;
          r[4*i +: 4] = s[3:0];
        end
      end
    endcase
  endtask

  // Present one op until accepted; expected result queued at the accept cycle
  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                      input logic [W-1:0] r, input logic [2:0] f);
    int n;
    bit done;
    n = 0;
    done = 0;
    opcode = op; alu_in1 = a; alu_in2 = b; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        sbq.push_back('{r: r, f: f});
        done = 1;
      end else if (n > 200) begin
        nvec++; nerr++;
        $display("FAIL accept_timeout: in_ready stuck 0 expected 1 at %0t", $time);
        done = 1;
      end
      n++;
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    alu_in1 = W'($urandom);
    alu_in2 = W'($urandom);
  endtask

  task automatic send_model(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    logic [W-1:0] r;
    logic [2:0] f;
    model(op, a, b, model_flags, r, f);
    model_flags = f;
    send(op, a, b, r, f);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((sbq.size() != 0 || pending) && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain_left", sbq.size() + int'(pending), 0);
  endtask

  // Output monitor: results in order, flags one cycle after each take
  always @(negedge clk) begin
    exp_t e;
    if (rst) begin
      pending = 0;
    end else begin
      if (pending) begin
        check("flags", 32'(flags), 32'(pend_flags));
        pending = 0;
      end
      if (out_valid && out_ready) begin
        if (sbq.size() == 0) begin
          nvec++; nerr++;
          $display("FAIL unexpected_output: got 0x%0h expected none at %0t", alu_out, $time);
        end else begin
          e = sbq.pop_front();
          check("alu_out", 32'(alu_out), 32'(e.r));
          pend_flags = e.f;
          pending = 1;
        end
      end
    end
  end

  // Random backpressure when enabled
  always @(posedge clk) begin
    if (rand_bp) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  vec_t tbl[19];
  logic [W-1:0] bp_a[5];
  logic [W-1:0] bp_b[5];
  logic [W-1:0] bp_r[5];
  logic [2:0]   bp_f[5];
  logic [2:0]   flags_before;
  int           idx;
  int           seen;

  initial begin
    // Expected flags accumulate from 000 down the table
    tbl[0]  = '{3'd0, 16'h7FFF, 16'h0001, 16'h7FFF, 3'b010};
    tbl[1]  = '{3'd0, 16'h8000, 16'h8001, 16'h8000, 3'b011};
    tbl[2]  = '{3'd0, 16'h0005, 16'hFFFB, 16'h0000, 3'b100};
    tbl[3]  = '{3'd1, 16'h8000, 16'h0001, 16'h8000, 3'b011};
    tbl[4]  = '{3'd2, 16'h00FF, 16'h00FF, 16'h0000, 3'b111};
    tbl[5]  = '{3'd3, 16'h0102, 16'h0304, 16'h000A, 3'b111};
    tbl[6]  = '{3'd3, 16'h7F40, 16'h0141, 16'h0001, 3'b111};
    tbl[7]  = '{3'd4, 16'h0001, 16'h0004, 16'h0010, 3'b011};
    tbl[8]  = '{3'd5, 16'h8000, 16'h000F, 16'hFFFF, 3'b011};
    tbl[9]  = '{3'd6, 16'h0001, 16'h0001, 16'h8000, 3'b011};
    tbl[10] = '{3'd7, 16'h7777, 16'h1111, 16'h7777, 3'b011};
    tbl[11] = '{3'd7, 16'h8888, 16'hFFFF, 16'h8888, 3'b011};
    tbl[12] = '{3'd4, 16'hA5A5, 16'h0000, 16'hA5A5, 3'b011};
    tbl[13] = '{3'd6, 16'h1234, 16'h0014, 16'h4123, 3'b011};
    tbl[14] = '{3'd1, 16'h0003, 16'h0003, 16'h0000, 3'b100};
    tbl[15] = '{3'd0, 16'h1234, 16'h1111, 16'h2345, 3'b000};
    tbl[16] = '{3'd7, 16'h9A52, 16'hC3E1, 16'h8D33, 3'b000};
    tbl[17] = '{3'd2, 16'h1234, 16'hFFFF, 16'hEDCB, 3'b000};
    tbl[18] = '{3'd5, 16'h4000, 16'h0003, 16'h0800, 3'b000};

    rst = 1'b1; in_valid = 1'b0; opcode = '0; alu_in1 = '0; alu_in2 = '0; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_alu_out", 32'(alu_out), 0);
    check("rst_flags", 32'(flags), 0);
    check("rst_in_ready", 32'(in_ready), 1);
    @(posedge clk); #1;

    // Table vectors, back-to-back with the consumer always ready
    for (int i = 0; i < 19; i++) begin
      send(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].r, tbl[i].f);
      model_flags = tbl[i].f;
    end
    drain();

    // Backpressure: five ADDs offered while the consumer stalls
    flags_before = model_flags;
    for (int i = 0; i < 5; i++) begin
      bp_a[i] = 16'h1000 * 16'(i + 1) + 16'h0101;
      bp_b[i] = (i == 4) ? 16'h7000 : 16'h0202;
      model(3'd0, bp_a[i], bp_b[i], model_flags, bp_r[i], bp_f[i]);
      model_flags = bp_f[i];
    end
    out_ready = 1'b0;
    idx = 0;
    opcode = 3'd0; alu_in1 = bp_a[0]; alu_in2 = bp_b[0]; in_valid = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (in_ready && in_valid) begin
        sbq.push_back('{r: bp_r[idx], f: bp_f[idx]});
        idx++;
      end
      @(posedge clk); #1;
      alu_in1 = bp_a[idx]; alu_in2 = bp_b[idx];
    end
    in_valid = 1'b0;
    check("bp_accepts", idx, 2);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("bp_in_ready", 32'(in_ready), 0);
      check("bp_out_valid", 32'(out_valid), 1);
      check("bp_alu_out_stable", 32'(alu_out), 32'(bp_r[0]));
      check("bp_flags_held", 32'(flags), 32'(flags_before));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    for (int i = idx; i < 5; i++) send(3'd0, bp_a[i], bp_b[i], bp_r[i], bp_f[i]);
    drain();
    @(negedge clk);
    check("bp_final_flags", 32'(flags), 32'(bp_f[4]));
    @(posedge clk); #1;

    // Reset with two ops in flight: nothing may emerge afterwards
    out_ready = 1'b0;
    send_model(3'd0, 16'h7FFF, 16'h7FFF);
    send_model(3'd1, 16'h0000, 16'h0001);
    rst = 1'b1;
    sbq.delete();
    model_flags = 3'b000;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    check("mid_rst_out_valid", 32'(out_valid), 0);
    check("mid_rst_alu_out", 32'(alu_out), 0);
    check("mid_rst_flags", 32'(flags), 0);
    check("mid_rst_in_ready", 32'(in_ready), 1);
    out_ready = 1'b1;
    seen = 0;
    for (int c = 0; c < 6; c++) begin
      @(negedge clk);
      if (out_valid) seen++;
    end
    check("mid_rst_no_ghost", seen, 0);
    @(posedge clk); #1;

    // Random ops with random consumer stalls
    rand_bp = 1;
    for (int i = 0; i < 600; i++) begin
      send_model(3'($urandom_range(0, 7)), W'($urandom), W'($urandom));
    end
    rand_bp = 0;
    @(posedge clk); #1;
    out_ready = 1'b1;
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
